n64_cmd_decode: RTL and testbench

N64_CMD_DECODE -- requirements
Module: n64_cmd_decode

---
 rtl/n64_pkg.sv | 65 ++++++
 rtl/n64_line_sampler.sv | 58 +++++
 rtl/n64_cmd_decode.sv | 156 +++++++++++++++
 tb/tb_n64_cmd_decode.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/n64_pkg.sv
// Shared constants, state encoding and command decode helper for the N64 command decoder.
// The optional majority filter is selected with N64_GLITCH_FILTER_EN (see n64_line_sampler).
package n64_pkg;

  localparam logic [6:0] SAMPLE_TICK  = 7'd24;
  localparam logic [6:0] TIMEOUT_TICK = 7'd96;
  localparam logic [6:0] GAP_TICK     = 7'd24;
  localparam logic [6:0] TICK_MAX     = 7'h7F;

  localparam logic LINE_IDLE = 1'b1;

  localparam logic [7:0] CMD_INFO   = 8'h00;
  localparam logic [7:0] CMD_RESET  = 8'hFF;
  localparam logic [7:0] CMD_STATUS = 8'h01;
  localparam logic [7:0] CMD_READ   = 8'h02;
  localparam logic [7:0] CMD_WRITE  = 8'h03;

  localparam logic [3:0] RESP_INFO   = 4'd0;
  localparam logic [3:0] RESP_STATUS = 4'd1;
  localparam logic [3:0] RESP_READ   = 4'd2;
  localparam logic [3:0] RESP_WRITE  = 4'd3;

  // Bits in a frame including the command byte; write carries 2 address + 32 data bytes.
  localparam logic [8:0] BITS_SHORT = 9'd8;
  localparam logic [8:0] BITS_READ  = 9'd24;
  localparam logic [8:0] BITS_WRITE = 9'd280;
  localparam logic [8:0] ADDR_END   = 9'd24;

  typedef enum logic [2:0] {
    StIdle,
    StBitLow,
    StBitHigh,
    StStop,
    StGap,
    StResp
  } state_e;

  typedef struct packed {
    logic       valid;
    logic [3:0] code;
    logic [8:0] total_bits;
  } cmd_info_t;

  function automatic cmd_info_t decode_cmd(input logic [7:0] cmd);
    cmd_info_t info;
    info.valid      = 1'b1;
    info.code       = RESP_INFO;
    info.total_bits = BITS_SHORT;
    case (cmd)
      CMD_INFO, CMD_RESET: info.code = RESP_INFO;
      CMD_STATUS:          info.code = RESP_STATUS;
      CMD_READ: begin
        info.code       = RESP_READ;
        info.total_bits = BITS_READ;
      end
      CMD_WRITE: begin
        info.code       = RESP_WRITE;
        info.total_bits = BITS_WRITE;
      end
      default:             info.valid = 1'b0;
    endcase
    return info;
  endfunction

endpackage

// File: rtl/n64_line_sampler.sv
// Synchronizes the raw N64 line, optionally majority-filters it (N64_GLITCH_FILTER_EN),
// and produces strobe-qualified falling/rising edge pulses.
module n64_line_sampler
  import n64_pkg::*;
(
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clk12_i,
  input  logic n64_in_i,
  output logic line_o,
  output logic fall_o,
  output logic rise_o
);

  logic sync1_q, sync2_q;
  logic prev_q;
  logic line;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q <= LINE_IDLE;
      sync2_q <= LINE_IDLE;
    end else if (clk12_i) begin
      sync1_q <= n64_in_i;
      sync2_q <= sync1_q;
    end
  end

`ifdef N64_GLITCH_FILTER_EN
  logic [2:0] win_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      win_q <= {3{LINE_IDLE}};
    end else if (clk12_i) begin
      win_q <= {win_q[1:0], sync2_q};
    end
  end

  // A single-sample pulse never wins the vote; real edges appear two strobes later.
  assign line = (win_q[0] & win_q[1]) | (win_q[0] & win_q[2]) | (win_q[1] & win_q[2]);
`else
  assign line = sync2_q;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      prev_q <= LINE_IDLE;
    end else if (clk12_i) begin
      prev_q <= line;
    end
  end

  assign line_o = line;
  assign fall_o = clk12_i & prev_q & ~line;
  assign rise_o = clk12_i & ~prev_q & line;

endmodule

// File: rtl/n64_cmd_decode.sv
// N64 console command frame decoder: decodes command byte, captures address, signals reply.
// Build with N64_GLITCH_FILTER_EN to add the 3-sample majority filter on the line.
module n64_cmd_decode
  import n64_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clk12,
  input  logic        n64_in,
  input  logic        resp_done,
  output logic [4:0]  Response,
  output logic [15:0] addr,
  output logic        cmd_valid,
  output logic        frame_err
);

  logic line, fall, rise;

  n64_line_sampler u_sampler (
    .clk_i    (clk),
    .rst_ni   (rst_n),
    .clk12_i  (clk12),
    .n64_in_i (n64_in),
    .line_o   (line),
    .fall_o   (fall),
    .rise_o   (rise)
  );

  state_e      state_q;
  logic [6:0]  tick_q, tick_d;
  logic [6:0]  run_q, run_d;
  logic [8:0]  bit_cnt_q, total_q;
  logic [7:0]  cmd_sh_q;
  logic [15:0] addr_sh_q;
  logic [3:0]  code_q;
  logic [4:0]  resp_q;
  logic [15:0] addr_q;
  logic        cmd_valid_q, frame_err_q;

  logic        line_edge, sample_now, run_timeout, gap_done, last_bit, has_addr;
  logic [7:0]  cmd_byte;
  cmd_info_t   cmd_info;

  // tick_q measures time since the last falling edge; run_q measures how long the line
  // has held its current level and drives the stuck-line timeout and the reply gap.
  always_comb begin
    line_edge   = fall | rise;
    tick_d      = (tick_q == TICK_MAX) ? tick_q : tick_q + 7'd1;
    run_d       = line_edge ? 7'd0 : ((run_q == TICK_MAX) ? run_q : run_q + 7'd1);
    sample_now  = (tick_q == SAMPLE_TICK - 7'd1);
    run_timeout = !line_edge && (run_q >= TIMEOUT_TICK - 7'd1);
    gap_done    = !line_edge && (run_q >= GAP_TICK - 7'd1);
    cmd_byte    = {cmd_sh_q[6:0], line};
    cmd_info    = decode_cmd(cmd_byte);
    last_bit    = (bit_cnt_q == total_q);
    has_addr    = (code_q == RESP_READ) || (code_q == RESP_WRITE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      tick_q      <= 7'd0;
      run_q       <= 7'd0;
      bit_cnt_q   <= 9'd0;
      total_q     <= 9'd0;
      cmd_sh_q    <= 8'd0;
      addr_sh_q   <= 16'd0;
      code_q      <= 4'd0;
      resp_q      <= 5'd0;
      addr_q      <= 16'd0;
      cmd_valid_q <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      cmd_valid_q <= 1'b0;
      frame_err_q <= 1'b0;
      if (clk12) begin
        tick_q <= tick_d;
        run_q  <= run_d;
        unique case (state_q)
          StIdle: begin
            if (fall) begin
              state_q   <= StBitLow;
              tick_q    <= 7'd0;
              bit_cnt_q <= 9'd0;
              total_q   <= BITS_SHORT;
            end
          end
          StBitLow: begin
            if (sample_now) begin
              bit_cnt_q <= bit_cnt_q + 9'd1;
              state_q   <= StBitHigh;
              if (bit_cnt_q < BITS_SHORT) begin
                cmd_sh_q <= cmd_byte;
              end else if (bit_cnt_q < ADDR_END) begin
                addr_sh_q <= {addr_sh_q[14:0], line};
              end
              if (bit_cnt_q == BITS_SHORT - 9'd1) begin
                if (cmd_info.valid) begin
                  code_q  <= cmd_info.code;
                  total_q <= cmd_info.total_bits;
                end else begin
                  frame_err_q <= 1'b1;
                  state_q     <= StIdle;
                end
              end
            end
          end
          StBitHigh: begin
            if (fall) begin
              tick_q  <= 7'd0;
              state_q <= last_bit ? StStop : StBitLow;
            end else if (run_timeout) begin
              frame_err_q <= 1'b1;
              state_q     <= StIdle;
            end
          end
          StStop: begin
            if (rise) begin
              state_q <= StGap;
            end else if (run_timeout) begin
              frame_err_q <= 1'b1;
              state_q     <= StIdle;
            end
          end
          StGap: begin
            if (fall) begin
              frame_err_q <= 1'b1;
              state_q     <= StIdle;
            end else if (gap_done) begin
              resp_q      <= {1'b1, code_q};
              cmd_valid_q <= 1'b1;
              if (has_addr) begin
                addr_q <= addr_sh_q;
              end
              state_q <= StResp;
            end
          end
          StResp: begin
            // Line activity is ignored here, so a same-strobe falling edge is dropped.
            if (resp_done) begin
              resp_q[4] <= 1'b0;
              state_q   <= StIdle;
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  assign Response  = resp_q;
  assign addr      = addr_q;
  assign cmd_valid = cmd_valid_q;
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_n64_cmd_decode.sv
// Self-checking bench for n64_cmd_decode: vector table, corner sequences, random frames.
module tb_n64_cmd_decode;

  logic        clk, rst_n, clk12, n64_in, resp_done;
  logic [4:0]  Response;
  logic [15:0] addr;
  logic        cmd_valid, frame_err;

  int checks = 0;
  int errors = 0;
  int n_valid = 0;
  int n_err = 0;

`ifdef N64_GLITCH_FILTER_EN
  localparam int Lat = 4;
`else
  localparam int Lat = 2;
`endif

  n64_cmd_decode dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clk12     (clk12),
    .n64_in    (n64_in),
    .resp_done (resp_done),
    .Response  (Response),
    .addr      (addr),
    .cmd_valid (cmd_valid),
    .frame_err (frame_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Strobe every second clock so clk12 qualification is exercised.
  initial begin
    clk12 = 1'b0;
    forever begin
      @(negedge clk);
      clk12 = 1'b1;
      @(negedge clk);
      clk12 = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (cmd_valid) n_valid++;
      if (frame_err) n_err++;
    end
  end

  typedef struct {
    logic [7:0]  cmd;
    logic [15:0] a;
    int          npay;
    bit          stop;
    logic [4:0]  exp_resp;
    logic [15:0] exp_addr;
    int          exp_valid;
    int          exp_err;
  } vec_t;

  vec_t vecs[6];

  task automatic tick();
    @(posedge clk);
    while (!clk12) @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  task automatic send_bit(input logic b);
    n64_in = 1'b0;
    ticks(b ? 12 : 36);
    n64_in = 1'b1;
    ticks(b ? 36 : 12);
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) send_bit(v[i]);
  endtask

  task automatic send_stop();
    n64_in = 1'b0;
    ticks(12);
    n64_in = 1'b1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic run_frame(input logic [7:0] cmd, input logic [15:0] a, input int npay,
                           input bit stop, input logic [4:0] exp_resp,
                           input logic [15:0] exp_addr, input int exp_valid, input int exp_err,
                           input bit do_done, input string tag);
    int v0, e0;
    logic [7:0] b;
    v0 = n_valid;
    e0 = n_err;
    send_byte(cmd);
    for (int i = 0; i < npay; i++) begin
      b = (i == 0) ? a[15:8] : (i == 1) ? a[7:0] : 8'($urandom);
      send_byte(b);
    end
    if (stop) send_stop();
    ticks(40);
    check({tag, " Response"}, 32'(Response), 32'(exp_resp));
    check({tag, " addr"}, 32'(addr), 32'(exp_addr));
    check({tag, " cmd_valid pulses"}, 32'(n_valid - v0), 32'(exp_valid));
    check({tag, " frame_err pulses"}, 32'(n_err - e0), 32'(exp_err));
    if (do_done && exp_resp[4]) begin
      resp_done = 1'b1;
      tick();
      check({tag, " Response after resp_done"}, 32'(Response), 32'({1'b0, exp_resp[3:0]}));
      resp_done = 1'b0;
      ticks(4);
    end
  endtask

  // Reference: what a frame should do, from the command table alone.
  function automatic void ref_model(input logic [7:0] cmd, input logic [15:0] a,
                                    inout logic [3:0] m_code, inout logic [15:0] m_addr,
                                    output int npay, output logic [4:0] resp,
                                    output int nv, output int ne);
    logic ok;
    logic [3:0] code;
    ok = 1'b1;
    code = 4'd0;
    npay = 0;
    case (cmd)
      8'h00, 8'hFF: code = 4'd0;
      8'h01:        code = 4'd1;
      8'h02: begin code = 4'd2; npay = 2; end
      8'h03: begin code = 4'd3; npay = 34; end
      default:      ok = 1'b0;
    endcase
    if (ok) begin
      m_code = code;
      if (npay > 0) m_addr = a;
      resp = {1'b1, code};
      nv = 1;
      ne = 0;
    end else begin
      resp = {1'b0, m_code};
      nv = 0;
      ne = 1;
    end
  endfunction

  initial begin
    int v0, e0, npay, nv, ne;
    logic [3:0]  m_code;
    logic [15:0] m_addr, ra;
    logic [4:0]  eresp;
    logic [7:0]  c;

    vecs[0] = '{8'h55, 16'h0000, 0,  1'b0, 5'b00000, 16'h0000, 0, 1};
    vecs[1] = '{8'h01, 16'h0000, 0,  1'b1, 5'b10001, 16'h0000, 1, 0};
    vecs[2] = '{8'h02, 16'h801B, 2,  1'b1, 5'b10010, 16'h801B, 1, 0};
    vecs[3] = '{8'h03, 16'h1234, 34, 1'b1, 5'b10011, 16'h1234, 1, 0};
    vecs[4] = '{8'hFF, 16'h0000, 0,  1'b1, 5'b10000, 16'h1234, 1, 0};
    vecs[5] = '{8'h02, 16'hABCD, 2,  1'b1, 5'b10010, 16'hABCD, 1, 0};

    rst_n = 1'b0;
    n64_in = 1'b1;
    resp_done = 1'b0;
    ticks(4);
    check("reset Response", 32'(Response), 32'h0);
    check("reset addr", 32'(addr), 32'h0);
    check("reset cmd_valid", 32'(cmd_valid), 32'h0);
    check("reset frame_err", 32'(frame_err), 32'h0);
    rst_n = 1'b1;
    ticks(10);

    for (int i = 0; i < 6; i++) begin
      run_frame(vecs[i].cmd, vecs[i].a, vecs[i].npay, vecs[i].stop, vecs[i].exp_resp,
                vecs[i].exp_addr, vecs[i].exp_valid, vecs[i].exp_err, 1'b1,
                $sformatf("vec%0d", i));
    end

    // Line held low for 100 ticks.
    e0 = n_err;
    v0 = n_valid;
    n64_in = 1'b0;
    ticks(100);
    n64_in = 1'b1;
    ticks(40);
    check("low timeout frame_err", 32'(n_err - e0), 32'd1);
    check("low timeout cmd_valid", 32'(n_valid - v0), 32'd0);
    check("low timeout Response", 32'(Response), 32'(5'b00010));

    // Five bits then the line stays high: dropped, address untouched.
    e0 = n_err;
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1); send_bit(1'b0);
    ticks(120);
    check("short frame frame_err", 32'(n_err - e0), 32'd1);
    check("short frame addr", 32'(addr), 32'hABCD);
    check("short frame Response", 32'(Response), 32'(5'b00010));

    // resp_done and a falling edge reach the decoder on the same strobe.
    run_frame(8'h01, 16'h0, 0, 1'b1, 5'b10001, 16'hABCD, 1, 0, 1'b0, "status hold");
    e0 = n_err;
    v0 = n_valid;
    n64_in = 1'b0;
    repeat (Lat) tick();
    resp_done = 1'b1;
    tick();
    resp_done = 1'b0;
    ticks(8);
    n64_in = 1'b1;
    ticks(150);
    check("priority Response", 32'(Response), 32'(5'b00001));
    check("priority frame_err", 32'(n_err - e0), 32'd0);
    check("priority cmd_valid", 32'(n_valid - v0), 32'd0);

    // Reset during bit 5 of a read command.
    for (int i = 0; i < 5; i++) send_bit(1'b0);
    n64_in = 1'b0;
    ticks(6);
    rst_n = 1'b0;
    #2;
    check("async reset Response", 32'(Response), 32'h0);
    check("async reset addr", 32'(addr), 32'h0);
    n64_in = 1'b1;
    ticks(3);
    rst_n = 1'b1;
    ticks(10);
    run_frame(8'h00, 16'h0, 0, 1'b1, 5'b10000, 16'h0000, 1, 0, 1'b1, "after reset");

`ifdef N64_GLITCH_FILTER_EN
    e0 = n_err;
    v0 = n_valid;
    n64_in = 1'b0;
    tick();
    n64_in = 1'b1;
    ticks(150);
    check("glitch frame_err", 32'(n_err - e0), 32'd0);
    check("glitch cmd_valid", 32'(n_valid - v0), 32'd0);
    run_frame(8'hFF, 16'h0, 0, 1'b1, 5'b10000, 16'h0000, 1, 0, 1'b1, "after glitch");
`endif

    m_code = 4'd0;
    m_addr = 16'h0000;
    for (int n = 0; n < 8; n++) begin
      case ($urandom_range(0, 5))
        0: c = 8'h00;
        1: c = 8'hFF;
        2: c = 8'h01;
        3, 5: c = 8'h02;
        default: begin
          do c = 8'($urandom);
          while (c == 8'h00 || c == 8'h01 || c == 8'h02 || c == 8'h03 || c == 8'hFF);
        end
      endcase
      ra = 16'($urandom);
      ref_model(c, ra, m_code, m_addr, npay, eresp, nv, ne);
      run_frame(c, ra, npay, (ne == 0), eresp, m_addr, nv, ne, 1'b1,
                $sformatf("rand%0d cmd=%02h", n, c));
      ticks($urandom_range(5, 30));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
